fpga_btn_reset_ctrl: RTL and testbench

//  Board-level reset sequencer for the FPGA tops (OrangeCrab-class boards).

---
 rtl/fpga_btn_reset_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_fpga_btn_reset_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_btn_reset_ctrl.sv
// Board reset sequencer: debounces the user button, turns a short press into a SoC
// reset pulse and a long press (after release) into a bootloader board reset.
module fpga_btn_reset_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 48000,
    parameter int unsigned LONG_PRESS_CYCLES = 96000000,
    parameter int unsigned SOC_RST_CYCLES    = 16,
    parameter int unsigned HEARTBEAT_CYCLES  = 24000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       usr_btn,
    output logic       soc_rst_n_out,
    output logic       board_rst_n,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESSED = 3'd1,
        ST_ARMED   = 3'd2,
        ST_SOC_RST = 3'd3,
        ST_BOOT    = 3'd4
    } state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int PULSE_W = $clog2(SOC_RST_CYCLES + 1);
    localparam int HB_W = $clog2(HEARTBEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(SOC_RST_CYCLES - 1);
    localparam logic [HB_W-1:0]    HB_LAST    = HB_W'(HEARTBEAT_CYCLES - 1);

    state_t              state;
    state_t              state_d;
    logic                btn_meta;
    logic                btn_s;
    logic                btn_db;
    logic                db_rise;
    logic                db_fall;
    logic [DB_W-1:0]     db_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [PULSE_W-1:0]  pulse_cnt;
    logic [HB_W-1:0]     hb_cnt;
    logic [HB_W-1:0]     hb_cnt_d;
    logic                hb_led;
    logic                hb_led_d;
    logic                soc_d;
    logic                board_d;
    logic                r_d;
    logic                g_d;
    logic                b_d;

    assign state_dbg = state;

    // Synchroniser flops reset to "released" so a held button is seen as a fresh press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_meta <= 1'b1;
            btn_s    <= 1'b1;
        end else begin
            btn_meta <= usr_btn;
            btn_s    <= btn_meta;
        end
    end

    // db_rise/db_fall are one-cycle pulses aligned with the btn_db update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_db  <= 1'b1;
            db_cnt  <= '0;
            db_rise <= 1'b0;
            db_fall <= 1'b0;
        end else begin
            db_rise <= 1'b0;
            db_fall <= 1'b0;
            if (btn_s != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db  <= btn_s;
                    db_cnt  <= '0;
                    db_rise <= btn_s;
                    db_fall <= ~btn_s;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (db_fall) state_d = ST_PRESSED;
            end
            ST_PRESSED: begin
                // A release landing on the threshold cycle still counts as a short press.
                if (db_rise) state_d = ST_SOC_RST;
                else if (hold_cnt == HOLD_LAST) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (db_rise) state_d = ST_BOOT;
            end
            ST_SOC_RST: begin
                if (pulse_cnt == PULSE_LAST) state_d = ST_IDLE;
            end
            ST_BOOT: begin
                state_d = ST_BOOT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            pulse_cnt <= '0;
        end else begin
            if (state != ST_PRESSED) hold_cnt <= '0;
            else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;

            if (state == ST_SOC_RST && state_d == ST_SOC_RST) pulse_cnt <= pulse_cnt + 1'b1;
            else pulse_cnt <= '0;
        end
    end

    // Heartbeat only runs while staying in IDLE; any entry restarts it dark.
    always_comb begin
        hb_cnt_d = '0;
        hb_led_d = 1'b1;
        if (state == ST_IDLE && state_d == ST_IDLE) begin
            if (hb_cnt == HB_LAST) begin
                hb_cnt_d = '0;
                hb_led_d = ~hb_led;
            end else begin
                hb_cnt_d = hb_cnt + 1'b1;
                hb_led_d = hb_led;
            end
        end
    end

    always_comb begin
        soc_d   = !(state_d == ST_SOC_RST || state_d == ST_BOOT);
        board_d = (state_d != ST_BOOT);
        r_d     = !(state_d == ST_PRESSED || state_d == ST_ARMED || state_d == ST_BOOT);
        b_d     = !(state_d == ST_SOC_RST || state_d == ST_BOOT);
        g_d     = 1'b1;
        case (state_d)
            ST_IDLE:  g_d = hb_led_d;
            ST_ARMED: g_d = 1'b0;
            ST_BOOT:  g_d = 1'b0;
            default:  g_d = 1'b1;
        endcase
    end

    // Outputs are registered so the board reset pin never sees decode glitches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hb_cnt        <= '0;
            hb_led        <= 1'b1;
            soc_rst_n_out <= 1'b0;
            board_rst_n   <= 1'b1;
            led_r         <= 1'b1;
            led_g         <= 1'b1;
            led_b         <= 1'b1;
        end else begin
            hb_cnt        <= hb_cnt_d;
            hb_led        <= hb_led_d;
            soc_rst_n_out <= soc_d;
            board_rst_n   <= board_d;
            led_r         <= r_d;
            led_g         <= g_d;
            led_b         <= b_d;
        end
    end

endmodule

// File: tb/tb_fpga_btn_reset_ctrl.sv
// Bench for fpga_btn_reset_ctrl: button waveforms are turned into expected per-cycle
// output vectors by a run-length/event model and checked by an independent monitor.
module tb_fpga_btn_reset_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 100;
    localparam int SOCN = 8;
    localparam int HB   = 10;

    logic       clk;
    logic       rst_n;
    logic       usr_btn;
    logic       soc_rst_n_out;
    logic       board_rst_n;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic [2:0] state_dbg;

    fpga_btn_reset_ctrl #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .SOC_RST_CYCLES   (SOCN),
        .HEARTBEAT_CYCLES (HB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .usr_btn      (usr_btn),
        .soc_rst_n_out(soc_rst_n_out),
        .board_rst_n  (board_rst_n),
        .led_r        (led_r),
        .led_g        (led_g),
        .led_b        (led_b),
        .state_dbg    (state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // vector layout: {state[2:0], soc_rst_n_out, board_rst_n, led_r, led_g, led_b}
    logic [7:0] exp_q[$];
    bit         wave_q[$];
    int         m_st[];
    int         m_ent[];
    int         m_n;
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         mon_en = 0;
    logic [7:0] got_v;
    logic [7:0] exp_v;
    logic [7:0] rst_vec = 8'b000_0_1_111;
    int         seg_sel;
    int         seg_len;
    int         seg_tot;
    bit         seg_lvl;

    function automatic logic [7:0] exp_vec(input int s, input int j, input int e);
        logic soc, brd, r, g, b;
        soc = !(s == 3 || s == 4);
        brd = (s != 4);
        r   = !(s == 1 || s == 2 || s == 4);
        b   = !(s == 3 || s == 4);
        case (s)
            0:       g = ((((j - e) / HB) % 2) == 0);
            2, 4:    g = 1'b0;
            default: g = 1'b1;
        endcase
        return {3'(s), soc, brd, r, g, b};
    endfunction

    task automatic fill_range(input int a, input int b, input int s, input int e);
        for (int j = a; j <= b; j++) begin
            if (j >= 0 && j <= m_n) begin
                m_st[j]  = s;
                m_ent[j] = e;
            end
        end
    endtask

    // Reference model: debounced edges from run lengths, then state spans from those edges.
    // Edge j (1-based) samples wave_q[j-1]; vector j is what the outputs show after edge j.
    task automatic model_phase(input int r_len);
        int  n, k, len, t0, idx, f, p, r;
        bit  db, done;
        int  ev_t[$];
        bit  ev_l[$];
        n     = wave_q.size();
        m_n   = n;
        m_st  = new[n + 1];
        m_ent = new[n + 1];
        for (int i = 0; i < r_len; i++) exp_q.push_back(rst_vec);
        db = 1'b1;
        k  = 0;
        while (k < n) begin
            len = 1;
            while (k + len < n && wave_q[k + len] == wave_q[k]) len++;
            if (wave_q[k] != db && len >= DEB) begin
                ev_t.push_back(k + DEB + 2);
                ev_l.push_back(wave_q[k]);
                db = wave_q[k];
            end
            k += len;
        end
        t0   = 0;
        idx  = 0;
        done = 1'b0;
        while (!done) begin
            while (idx < ev_t.size() && !(ev_l[idx] == 1'b0 && ev_t[idx] >= t0)) idx++;
            if (idx >= ev_t.size()) begin
                fill_range(t0, n, 0, t0);
                done = 1'b1;
            end else begin
                f = ev_t[idx];
                p = f + 1;
                fill_range(t0, p - 1, 0, t0);
                if (idx + 1 < ev_t.size() && ev_t[idx + 1] - p <= LONG - 1) begin
                    r = ev_t[idx + 1];
                    fill_range(p, r, 1, 0);
                    fill_range(r + 1, r + SOCN, 3, 0);
                    t0 = r + SOCN + 1;
                    idx += 2;
                end else begin
                    fill_range(p, p + LONG - 1, 1, 0);
                    if (idx + 1 < ev_t.size()) begin
                        r = ev_t[idx + 1];
                        fill_range(p + LONG, r, 2, 0);
                        fill_range(r + 1, n, 4, 0);
                    end else begin
                        fill_range(p + LONG, n, 2, 0);
                    end
                    done = 1'b1;
                end
            end
        end
        for (int j = 1; j <= n; j++) exp_q.push_back(exp_vec(m_st[j], j, m_ent[j]));
    endtask

    // driver tasks
    task automatic drive_cycle(input logic r, input logic b);
        rst_n   = r;
        usr_btn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic wave_add(input bit lvl, input int len);
        for (int i = 0; i < len; i++) wave_q.push_back(lvl);
    endtask

    task automatic run_phase(input int r_len);
        model_phase(r_len);
        for (int i = 0; i < r_len; i++) drive_cycle(1'b0, 1'b1);
        for (int i = 0; i < wave_q.size(); i++) drive_cycle(1'b1, wave_q[i]);
        wave_q.delete();
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            got_v = {state_dbg, soc_rst_n_out, board_rst_n, led_r, led_g, led_b};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL underflow cyc=%0d got=%b required=<queued vector>", cyc, got_v);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v) begin
                    n_err++;
                    $display("FAIL outputs cyc=%0d got=%b required=%b", cyc, got_v, exp_v);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        usr_btn = 1'b1;
        drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b0, 1'b1);
        @(negedge clk);
        #1;
        mon_en = 1'b1;

        // reset then idle heartbeat
        wave_add(1, 40);
        run_phase(3);
        // glitch shorter than the debounce window
        wave_add(1, 5); wave_add(0, 3); wave_add(1, 30);
        run_phase(2);
        // short press
        wave_add(1, 5); wave_add(0, 40); wave_add(1, 40);
        run_phase(2);
        // long press, release into BOOT, later presses ignored
        wave_add(1, 5); wave_add(0, 150); wave_add(1, 20); wave_add(0, 10); wave_add(1, 20);
        run_phase(2);
        // reset while in BOOT, then long press left in ARMED
        wave_add(1, 5); wave_add(0, 150);
        run_phase(2);
        // one-cycle reset while ARMED, button still held afterwards
        wave_add(0, 20); wave_add(1, 40);
        run_phase(1);
        // release just below and exactly on the long-press threshold
        wave_add(1, 5); wave_add(0, 99); wave_add(1, 30); wave_add(0, 100); wave_add(1, 30);
        run_phase(2);
        // one cycle past the threshold
        wave_add(1, 5); wave_add(0, 101); wave_add(1, 30);
        run_phase(2);
        // press during the SoC pulse is ignored until release and fresh press
        wave_add(1, 5); wave_add(0, 20); wave_add(1, 4); wave_add(0, 30); wave_add(1, 30);
        wave_add(0, 15); wave_add(1, 30);
        run_phase(2);

        for (int ph = 0; ph < 8; ph++) begin
            wave_add(1, 5);
            seg_tot = 0;
            seg_lvl = 1'b0;
            while (seg_tot < 300) begin
                seg_sel = $urandom_range(0, 9);
                if (seg_sel < 3) seg_len = $urandom_range(1, 3);
                else if (seg_sel < 8) seg_len = $urandom_range(4, 40);
                else seg_len = $urandom_range(95, 105);
                wave_add(seg_lvl, seg_len);
                seg_tot += seg_len;
                seg_lvl = !seg_lvl;
            end
            run_phase($urandom_range(1, 3));
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover got=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
